sdram_arbiter: RTL and testbench

- Single-clock-domain arbiter between SDRAM_16bit and its two clients: the video refill path (vqueue) and the cache_controller line fill/flush path.
- Selects one SDRAM command per cycle, with video read having top priority.
- Generates the SDRAM word address for each command and owns the video line address counter, including wrap at end of frame.
- Steers the 16-bit SDRAM data strobes to the owning client and packs video halfwords into 32-bit queue words.

---
 rtl/sdram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Arbitrates SDRAM_16bit between the video refill path (vqueue) and the
//   cache_controller line fill/flush path. Issues one registered command per
//   cycle (video read has top priority), forms the SDRAM word address, owns
//   the video burst counter (wraps once per frame), routes the 16-bit data
//   strobes to the owning client and packs video halfwords into 32-bit words.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   vid_enable, vid_need   video fetch allowed / vqueue almost empty
//   cache_wr_req/rd_req    cache write-back / line fill requests
//   cache_waddr/raddr      cache line addresses (17 bit)
//   sys_cmd, sys_addr      command (00 nop, 01 wr256, 10 rd32, 11 rd256) + word address
//   sys_cmd_ack            command code accepted by SDRAM_16bit (00 idle)
//   sys_rd/wr_data_valid   read / write halfword strobes
//   sys_dout               SDRAM read data
//   cache_fill_we          cache captures sys_dout
//   cache_drain_re         cache presents next write halfword
//   vq_data, vq_we         packed video word {second, first} and its write enable
//   frame_wrap             one-cycle pulse when the video counter wraps to 0
//   owner_vid              video owns the data strobes
//
// Owner FSM
//   state    | meaning
//   ST_CACHE | data strobes belong to the cache controller
//   ST_VID   | data strobes belong to the video packer

module sdram_arbiter #(
    parameter int VID_LINES = 19200,
    parameter int VID_AW    = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vid_enable,
    input  logic        vid_need,
    input  logic        cache_wr_req,
    input  logic        cache_rd_req,
    input  logic [16:0] cache_waddr,
    input  logic [16:0] cache_raddr,
    output logic [1:0]  sys_cmd,
    output logic [22:0] sys_addr,
    input  logic [1:0]  sys_cmd_ack,
    input  logic        sys_rd_data_valid,
    input  logic        sys_wr_data_valid,
    input  logic [15:0] sys_dout,
    output logic        cache_fill_we,
    output logic        cache_drain_re,
    output logic [31:0] vq_data,
    output logic        vq_we,
    output logic        frame_wrap,
    output logic        owner_vid
);

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WR256 = 2'b01;
    localparam logic [1:0] CMD_RD32  = 2'b10;
    localparam logic [1:0] CMD_RD256 = 2'b11;

    localparam logic [VID_AW-1:0] VID_LAST = VID_AW'(VID_LINES - 1);

    typedef enum logic {ST_CACHE = 1'b0, ST_VID = 1'b1} owner_t;

    owner_t              r_state;
    owner_t              w_state_next;
    logic [1:0]          r_sys_cmd;
    logic                r_ack_prev_zero;
    logic [VID_AW-1:0]   r_vid_cnt;
    logic                r_phase;
    logic [15:0]         r_lo;
    logic [31:0]         r_vq_data;
    logic                r_vq_we;
    logic                r_frame_wrap;

    logic                w_accept;
    logic                w_accept_vid;
    logic                w_vid_strobe;

    // One acceptance per ack episode: only the first non-zero ack cycle counts.
    assign w_accept     = r_ack_prev_zero && (sys_cmd_ack != CMD_NOP);
    assign w_accept_vid = w_accept && (sys_cmd_ack == CMD_RD32);
    assign w_vid_strobe = (r_state == ST_VID) && sys_rd_data_valid;

    // ---------------- owner FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CACHE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            w_state_next = (sys_cmd_ack == CMD_RD32) ? ST_VID : ST_CACHE;
        end
    end

    // Strobes follow the registered owner, so a strobe in the acceptance
    // cycle still goes to the previous owner.
    always_comb begin
        owner_vid      = (r_state == ST_VID);
        cache_fill_we  = (r_state == ST_CACHE) && sys_rd_data_valid;
        cache_drain_re = (r_state == ST_CACHE) && sys_wr_data_valid;
    end

    // ---------------- command select ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sys_cmd       <= CMD_NOP;
            r_ack_prev_zero <= 1'b1;
        end else begin
            r_ack_prev_zero <= (sys_cmd_ack == CMD_NOP);
            if (vid_enable && vid_need) begin
                r_sys_cmd <= CMD_RD32;
            end else if (cache_wr_req) begin
                r_sys_cmd <= CMD_WR256;
            end else if (cache_rd_req) begin
                r_sys_cmd <= CMD_RD256;
            end else begin
                r_sys_cmd <= CMD_NOP;
            end
        end
    end

    always_comb begin
        case (r_sys_cmd)
            CMD_WR256: sys_addr = {cache_waddr, 6'b0};
            CMD_RD32:  sys_addr = {1'b1, r_vid_cnt, 3'b0};
            CMD_RD256: sys_addr = {cache_raddr, 6'b0};
            default:   sys_addr = '0;
        endcase
    end

    // ---------------- video counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vid_cnt    <= '0;
            r_frame_wrap <= 1'b0;
        end else begin
            r_frame_wrap <= 1'b0;
            if (!vid_enable) begin
                r_vid_cnt <= '0;
            end else if (w_accept_vid) begin
                if (r_vid_cnt == VID_LAST) begin
                    r_vid_cnt    <= '0;
                    r_frame_wrap <= 1'b1;
                end else begin
                    r_vid_cnt <= r_vid_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- video packing ----------------
    // A new video acceptance restarts the pack phase so every burst starts
    // on a low halfword.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= 1'b0;
            r_lo      <= '0;
            r_vq_data <= '0;
            r_vq_we   <= 1'b0;
        end else begin
            r_vq_we <= 1'b0;
            if (w_vid_strobe) begin
                if (!r_phase) begin
                    r_lo <= sys_dout;
                end else begin
                    r_vq_data <= {sys_dout, r_lo};
                    r_vq_we   <= 1'b1;
                end
            end
            if (!vid_enable || w_accept_vid) begin
                r_phase <= 1'b0;
            end else if (w_vid_strobe) begin
                r_phase <= ~r_phase;
            end
        end
    end

    assign sys_cmd    = r_sys_cmd;
    assign vq_data    = r_vq_data;
    assign vq_we      = r_vq_we;
    assign frame_wrap = r_frame_wrap;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        vid_enable, vid_need, cache_wr_req, cache_rd_req;
    logic [16:0] cache_waddr, cache_raddr;
    logic [1:0]  sys_cmd;
    logic [22:0] sys_addr;
    logic [1:0]  sys_cmd_ack;
    logic        sys_rd_data_valid, sys_wr_data_valid;
    logic [15:0] sys_dout;
    logic        cache_fill_we, cache_drain_re;
    logic [31:0] vq_data;
    logic        vq_we, frame_wrap, owner_vid;

    int errors = 0;
    int checks = 0;
    int wraps  = 0;

    sdram_arbiter dut (
        .clk(clk), .rst(rst), .vid_enable(vid_enable), .vid_need(vid_need),
        .cache_wr_req(cache_wr_req), .cache_rd_req(cache_rd_req),
        .cache_waddr(cache_waddr), .cache_raddr(cache_raddr),
        .sys_cmd(sys_cmd), .sys_addr(sys_addr), .sys_cmd_ack(sys_cmd_ack),
        .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
        .sys_dout(sys_dout), .cache_fill_we(cache_fill_we), .cache_drain_re(cache_drain_re),
        .vq_data(vq_data), .vq_we(vq_we), .frame_wrap(frame_wrap), .owner_vid(owner_vid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_wrap === 1'b1) wraps++;

    // Inputs change at the negedge; outputs are sampled at the following negedge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic accept(input logic [1:0] code);
        sys_cmd_ack = code;
        cyc();
        sys_cmd_ack = 2'b00;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1; vid_enable = 0; vid_need = 0; cache_wr_req = 0; cache_rd_req = 0;
        cache_waddr = '0; cache_raddr = '0; sys_cmd_ack = 0;
        sys_rd_data_valid = 0; sys_wr_data_valid = 0; sys_dout = '0;
        cyc(); cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++;
            if (sys_cmd !== 2'b00 || sys_addr !== 23'd0 || vq_we !== 1'b0 || owner_vid !== 1'b0
                || frame_wrap !== 1'b0 || cache_fill_we !== 1'b0 || vq_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d cmd=%b addr=%h vq_we=%b owner=%b wrap=%b fill=%b vq_data=%h required all zero",
                         i, sys_cmd, sys_addr, vq_we, owner_vid, frame_wrap, cache_fill_we, vq_data);
            end
        end
    endtask

    task automatic test_video_burst();
        int pulses = 0;
        vid_enable = 1'b1;
        for (int i = 0; i < 5; i++) accept(2'b10);
        vid_need = 1'b0;
        cyc();
        checks++;
        if (sys_cmd !== 2'b00) begin
            errors++; $display("FAIL vid_idle_cmd got=%b exp=00", sys_cmd);
        end
        vid_need = 1'b1;
        cyc();
        checks++;
        if (sys_cmd !== 2'b10 || sys_addr !== 23'h400028) begin
            errors++; $display("FAIL vid_cmd5 cmd=%b addr=%h exp=10/400028", sys_cmd, sys_addr);
        end
        accept(2'b10);
        checks++;
        if (owner_vid !== 1'b1 || sys_addr !== 23'h400030) begin
            errors++; $display("FAIL vid_cnt6 owner=%b addr=%h exp=1/400030", owner_vid, sys_addr);
        end
        vid_need = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            sys_rd_data_valid = 1'b1; sys_wr_data_valid = 1'b1; sys_dout = 16'(i);
            #1;
            checks++;
            if (cache_fill_we !== 1'b0 || cache_drain_re !== 1'b0) begin
                errors++; $display("FAIL vid_no_cache i=%0d fill=%b drain=%b exp=0/0", i, cache_fill_we, cache_drain_re);
            end
            cyc();
            if (vq_we === 1'b1) pulses++;
            checks++;
            if (vq_we !== ((i % 2) == 0)) begin
                errors++; $display("FAIL vid_we i=%0d got=%b exp=%b", i, vq_we, (i % 2) == 0);
            end else if (vq_we && vq_data !== {16'(i), 16'(i - 1)}) begin
                errors++; $display("FAIL vid_data i=%0d got=%h exp=%h", i, vq_data, {16'(i), 16'(i - 1)});
            end
        end
        sys_rd_data_valid = 0; sys_wr_data_valid = 0;
        cyc();
        checks++;
        if (pulses !== 8 || vq_we !== 1'b0 || vq_data !== 32'h0010000F) begin
            errors++; $display("FAIL vid_pulses got=%0d we=%b last=%h exp=8/0/0010000f", pulses, vq_we, vq_data);
        end
    endtask

    task automatic test_frame_wrap();
        int w0;
        vid_need = 1'b1;
        cyc();
        for (int i = 6; i < 19199; i++) accept(2'b10);
        checks++;
        if (sys_addr !== 23'h4257F8 || wraps !== 0) begin
            errors++; $display("FAIL wrap_preload addr=%h wraps=%0d exp=4257f8/0", sys_addr, wraps);
        end
        w0 = wraps;
        sys_cmd_ack = 2'b10;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (frame_wrap !== (i == 0)) begin
                errors++; $display("FAIL wrap_pulse cyc=%0d got=%b exp=%b", i, frame_wrap, i == 0);
            end
        end
        sys_cmd_ack = 2'b00;
        cyc();
        checks++;
        if (sys_addr !== 23'h400000 || wraps - w0 !== 1) begin
            errors++; $display("FAIL wrap_held addr=%h pulses=%0d exp=400000/1", sys_addr, wraps - w0);
        end
    endtask

    task automatic test_cache_wr_rd();
        vid_need = 1'b0; cache_wr_req = 1; cache_rd_req = 1;
        cache_waddr = 17'h00123; cache_raddr = 17'h00456;
        cyc();
        checks++;
        if (sys_cmd !== 2'b01 || sys_addr !== 23'h0048C0) begin
            errors++; $display("FAIL cache_wr cmd=%b addr=%h exp=01/0048c0", sys_cmd, sys_addr);
        end
        sys_cmd_ack = 2'b01;
        cyc();
        cache_wr_req = 0; sys_cmd_ack = 2'b00;
        cyc();
        checks++;
        if (sys_cmd !== 2'b11 || sys_addr !== 23'h011580 || owner_vid !== 1'b0) begin
            errors++; $display("FAIL cache_rd cmd=%b addr=%h owner=%b exp=11/011580/0", sys_cmd, sys_addr, owner_vid);
        end
        sys_wr_data_valid = 1; #1;
        checks++;
        if (cache_drain_re !== 1'b1 || cache_fill_we !== 1'b0) begin
            errors++; $display("FAIL cache_drain drain=%b fill=%b exp=1/0", cache_drain_re, cache_fill_we);
        end
        sys_wr_data_valid = 0; sys_rd_data_valid = 1; #1;
        checks++;
        if (cache_fill_we !== 1'b1 || cache_drain_re !== 1'b0) begin
            errors++; $display("FAIL cache_fill fill=%b drain=%b exp=1/0", cache_fill_we, cache_drain_re);
        end
        cyc(); cyc();
        sys_rd_data_valid = 0;
        checks++;
        if (vq_we !== 1'b0) begin
            errors++; $display("FAIL cache_no_vq got=%b exp=0", vq_we);
        end
    endtask

    task automatic test_priority();
        vid_need = 1; cache_rd_req = 1;
        cyc();
        checks++;
        if (sys_cmd !== 2'b10) begin
            errors++; $display("FAIL prio_vid cmd=%b exp=10", sys_cmd);
        end
        sys_cmd_ack = 2'b10; sys_rd_data_valid = 1; #1;
        checks++;
        if (cache_fill_we !== 1'b1) begin
            errors++; $display("FAIL accept_cycle_owner fill=%b exp=1", cache_fill_we);
        end
        cyc();
        sys_cmd_ack = 0; sys_rd_data_valid = 0; vid_need = 0;
        cyc();
        checks++;
        if (sys_cmd !== 2'b11 || owner_vid !== 1'b1 || vq_we !== 1'b0) begin
            errors++; $display("FAIL prio_follow cmd=%b owner=%b vq_we=%b exp=11/1/0", sys_cmd, owner_vid, vq_we);
        end
        cache_rd_req = 0;
    endtask

    task automatic test_reset_mid_burst();
        for (int i = 1; i <= 5; i++) begin
            sys_rd_data_valid = 1; sys_dout = 16'h0100 + 16'(i);
            cyc();
        end
        rst = 1;
        cyc();
        rst = 0;
        #1;
        checks++;
        if (owner_vid !== 0 || vq_we !== 0 || vq_data !== 0 || sys_cmd !== 0 || cache_fill_we !== 1'b1) begin
            errors++; $display("FAIL rst_mid owner=%b we=%b data=%h cmd=%b fill=%b exp=0/0/0/00/1",
                               owner_vid, vq_we, vq_data, sys_cmd, cache_fill_we);
        end
        for (int i = 7; i <= 16; i++) begin
            sys_dout = 16'h0100 + 16'(i);
            #1;
            checks++;
            if (cache_fill_we !== 1'b1) begin
                errors++; $display("FAIL rst_tail_fill i=%0d got=%b exp=1", i, cache_fill_we);
            end
            cyc();
            checks++;
            if (vq_we !== 1'b0) begin
                errors++; $display("FAIL rst_tail_vq i=%0d got=%b exp=0", i, vq_we);
            end
        end
        sys_rd_data_valid = 0; vid_need = 1;
        cyc();
        checks++;
        if (sys_cmd !== 2'b10 || sys_addr !== 23'h400000) begin
            errors++; $display("FAIL rst_cnt cmd=%b addr=%h exp=10/400000", sys_cmd, sys_addr);
        end
        accept(2'b10);
        vid_need = 0;
        sys_rd_data_valid = 1; sys_dout = 16'hAAAA;
        cyc();
        checks++;
        if (vq_we !== 1'b0) begin
            errors++; $display("FAIL rst_phase_first got=%b exp=0", vq_we);
        end
        sys_dout = 16'hBBBB;
        cyc();
        sys_rd_data_valid = 0;
        checks++;
        if (vq_we !== 1'b1 || vq_data !== 32'hBBBBAAAA) begin
            errors++; $display("FAIL rst_phase_second we=%b data=%h exp=1/bbbbaaaa", vq_we, vq_data);
        end
    endtask

    task automatic test_vid_disable();
        vid_need = 1;
        cyc();
        checks++;
        if (sys_addr !== 23'h400008) begin
            errors++; $display("FAIL dis_pre addr=%h exp=400008", sys_addr);
        end
        vid_enable = 0;
        cyc();
        checks++;
        if (sys_cmd !== 2'b00) begin
            errors++; $display("FAIL dis_cmd cmd=%b exp=00", sys_cmd);
        end
        vid_enable = 1;
        cyc();
        checks++;
        if (sys_cmd !== 2'b10 || sys_addr !== 23'h400000) begin
            errors++; $display("FAIL dis_cnt cmd=%b addr=%h exp=10/400000", sys_cmd, sys_addr);
        end
        vid_need = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_video_burst();
        test_frame_wrap();
        test_cache_wr_rd();
        test_priority();
        test_reset_mid_burst();
        test_vid_disable();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
